// File: rtl/collision_tracker.sv
// Multi-row dino collision tracker: per-tick overlap check, lives, grace window, sticky game-over.
// Optional 2-column hitbox enabled by defining HITBOX_WIDE_EN.
module collision_tracker #(
    parameter int unsigned COLS        = 8,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned HIT_COL     = 7,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned GRACE_TICKS = 4,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned RW = $clog2(ROWS),
    localparam int unsigned LW = $clog2(LIVES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 restart,
    input  logic [ROWS*COLS-1:0] obstacle_map,
    input  logic [RW-1:0]        dino_row,
    output logic                 collision,
    output logic                 hit,
    output logic                 invuln,
    output logic [LW-1:0]        lives,
    output logic                 game_over,
    output logic [CNT_W-1:0]     hit_count
);

    localparam int unsigned GW = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
    localparam int unsigned WIDE_COL = (HIT_COL > 0) ? HIT_COL - 1 : HIT_COL;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_GRACE,
        ST_OVER
    } state_t;

    state_t           state_q, state_n;
    logic             collision_q, collision_n;
    logic             hit_q, hit_n;
    logic             invuln_q, invuln_n;
    logic [LW-1:0]    lives_q, lives_n;
    logic             game_over_q, game_over_n;
    logic [CNT_W-1:0] hit_count_q, hit_count_n;
    logic [GW-1:0]    grace_cnt_q, grace_cnt_n;
    logic             raw_hit;

    // Rows beyond ROWS never match the loop, so an out-of-range dino_row yields no hit.
    always_comb begin
        raw_hit = 1'b0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (dino_row == RW'(r)) begin
                raw_hit = obstacle_map[r*COLS + HIT_COL];
`ifdef HITBOX_WIDE_EN
                if (HIT_COL > 0) begin
                    raw_hit = raw_hit | obstacle_map[r*COLS + WIDE_COL];
                end
`endif
            end
        end
    end

    always_comb begin
        state_n     = state_q;
        collision_n = collision_q;
        hit_n       = 1'b0;
        invuln_n    = invuln_q;
        lives_n     = lives_q;
        game_over_n = game_over_q;
        hit_count_n = hit_count_q;
        grace_cnt_n = grace_cnt_q;

        if (restart) begin
            state_n     = ST_RUN;
            collision_n = 1'b0;
            invuln_n    = 1'b0;
            lives_n     = LW'(LIVES);
            game_over_n = 1'b0;
            hit_count_n = '0;
            grace_cnt_n = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (tick) begin
                        collision_n = raw_hit;
                        if (raw_hit) begin
                            hit_n   = 1'b1;
                            lives_n = lives_q - 1'b1;
                            if (hit_count_q != '1) begin
                                hit_count_n = hit_count_q + 1'b1;
                            end
                            if (lives_q == LW'(1)) begin
                                state_n     = ST_OVER;
                                game_over_n = 1'b1;
                                collision_n = 1'b0;
                            end else if (GRACE_TICKS > 0) begin
                                state_n     = ST_GRACE;
                                grace_cnt_n = GW'(GRACE_TICKS);
                                invuln_n    = 1'b1;
                            end
                        end
                    end
                end
                ST_GRACE: begin
                    if (tick) begin
                        collision_n = raw_hit;
                        grace_cnt_n = grace_cnt_q - 1'b1;
                        if (grace_cnt_q == GW'(1)) begin
                            state_n  = ST_RUN;
                            invuln_n = 1'b0;
                        end
                    end
                end
                ST_OVER: begin
                    collision_n = 1'b0;
                end
                default: begin
                    state_n = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            collision_q <= 1'b0;
            hit_q       <= 1'b0;
            invuln_q    <= 1'b0;
            lives_q     <= LW'(LIVES);
            game_over_q <= 1'b0;
            hit_count_q <= '0;
            grace_cnt_q <= '0;
        end else begin
            state_q     <= state_n;
            collision_q <= collision_n;
            hit_q       <= hit_n;
            invuln_q    <= invuln_n;
            lives_q     <= lives_n;
            game_over_q <= game_over_n;
            hit_count_q <= hit_count_n;
            grace_cnt_q <= grace_cnt_n;
        end
    end

    assign collision = collision_q;
    assign hit       = hit_q;
    assign invuln    = invuln_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_collision_tracker.sv
// Self-checking bench for collision_tracker (default parameters); vector table fed through a scoreboard queue.
module tb_collision_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        restart;
    logic [15:0] obstacle_map;
    logic [0:0]  dino_row;
    logic        collision;
    logic        hit;
    logic        invuln;
    logic [1:0]  lives;
    logic        game_over;
    logic [7:0]  hit_count;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        logic        restart;
        logic        tick;
        logic [15:0] map;
        logic [0:0]  row;
        logic        e_col;
        logic        e_hit;
        logic        e_inv;
        logic [1:0]  e_lives;
        logic        e_go;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    collision_tracker #(
        .COLS(8),
        .ROWS(2),
        .HIT_COL(7),
        .LIVES(3),
        .GRACE_TICKS(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .restart(restart),
        .obstacle_map(obstacle_map),
        .dino_row(dino_row),
        .collision(collision),
        .hit(hit),
        .invuln(invuln),
        .lives(lives),
        .game_over(game_over),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic c, input logic h, input logic i,
                             input logic [1:0] l, input logic g, input logic [7:0] n);
        check({tag, ".collision"}, int'(collision), int'(c));
        check({tag, ".hit"},       int'(hit),       int'(h));
        check({tag, ".invuln"},    int'(invuln),    int'(i));
        check({tag, ".lives"},     int'(lives),     int'(l));
        check({tag, ".game_over"}, int'(game_over), int'(g));
        check({tag, ".hit_count"}, int'(hit_count), int'(n));
    endtask

    function automatic vec_t mk(input logic r, input logic t, input logic [15:0] m, input logic [0:0] row,
                                input logic c, input logic h, input logic i, input logic [1:0] l,
                                input logic g, input logic [7:0] n);
        vec_t v;
        v.restart = r; v.tick = t; v.map = m; v.row = row;
        v.e_col = c; v.e_hit = h; v.e_inv = i; v.e_lives = l; v.e_go = g; v.e_cnt = n;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        restart = v.restart; tick = v.tick; obstacle_map = v.map; dino_row = v.row;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_all(tag, e.e_col, e.e_hit, e.e_inv, e.e_lives, e.e_go, e.e_cnt);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; restart = 1'b0; obstacle_map = '0; dino_row = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 8'd0);
        reset = 1'b1;

        //            R  T  map       row  col hit inv lives go cnt
        vecs.push_back(mk(0, 1, 16'h0080, 0, 1, 1, 1, 2'd2, 0, 8'd1)); // first hit
        vecs.push_back(mk(0, 0, 16'h0080, 0, 1, 0, 1, 2'd2, 0, 8'd1)); // no tick
        vecs.push_back(mk(0, 1, 16'h0080, 0, 1, 0, 1, 2'd2, 0, 8'd1)); // grace 1
        vecs.push_back(mk(0, 1, 16'h0080, 0, 1, 0, 1, 2'd2, 0, 8'd1)); // grace 2
        vecs.push_back(mk(0, 1, 16'h0080, 0, 1, 0, 1, 2'd2, 0, 8'd1)); // grace 3
        vecs.push_back(mk(0, 1, 16'h0080, 0, 1, 0, 0, 2'd2, 0, 8'd1)); // grace 4, immune
        vecs.push_back(mk(0, 1, 16'h0080, 0, 1, 1, 1, 2'd1, 0, 8'd2)); // second hit
        vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 1, 2'd1, 0, 8'd2));
        vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 1, 2'd1, 0, 8'd2));
        vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 1, 2'd1, 0, 8'd2));
        vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 0, 2'd1, 0, 8'd2));
        vecs.push_back(mk(0, 1, 16'h0080, 1, 0, 0, 0, 2'd1, 0, 8'd2)); // row1, ground obstacle
        vecs.push_back(mk(0, 1, 16'h8000, 1, 0, 1, 0, 2'd0, 1, 8'd3)); // fatal hit
        vecs.push_back(mk(0, 1, 16'h8000, 1, 0, 0, 0, 2'd0, 1, 8'd3)); // over: frozen
        vecs.push_back(mk(0, 1, 16'h8080, 0, 0, 0, 0, 2'd0, 1, 8'd3));
        vecs.push_back(mk(1, 1, 16'h0080, 0, 0, 0, 0, 2'd3, 0, 8'd0)); // restart beats tick
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 2'd3, 0, 8'd0));
`ifdef HITBOX_WIDE_EN
        vecs.push_back(mk(0, 1, 16'h0040, 0, 1, 1, 1, 2'd2, 0, 8'd1)); // 2-column hitbox
`else
        vecs.push_back(mk(0, 1, 16'h0040, 0, 0, 0, 0, 2'd3, 0, 8'd0)); // single column
`endif
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 2'd3, 0, 8'd0));

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Overlap present but no tick: nothing may change.
        for (int i = 0; i < 10; i++)
            step(mk(0, 0, 16'h0080, 0, 0, 0, 0, 2'd3, 0, 8'd0), $sformatf("notick%0d", i));
        step(mk(0, 1, 16'h0080, 0, 1, 1, 1, 2'd2, 0, 8'd1), "hit_after_idle");
        for (int i = 0; i < 10; i++)
            step(mk(0, 0, 16'h0000, 0, 1, 0, 1, 2'd2, 0, 8'd1), $sformatf("hold%0d", i));

        // Asynchronous reset while in grace takes effect before the next edge.
        #2 reset = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 8'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(mk(0, 1, 16'h0000, 0, 0, 0, 0, 2'd3, 0, 8'd0), "post_reset");
        step(mk(0, 1, 16'h0080, 0, 1, 1, 1, 2'd2, 0, 8'd1), "post_reset_hit");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/collision_tracker.md
Name: collision_tracker

Overview:
Parametrised successor to the single-row collision checker in the dino game. Checks a multi-row obstacle map against the dino's row at a configurable hit column, once per frame tick. Tracks lives, applies a grace (invulnerability) window after each hit and raises a sticky game-over flag. Sits between the obstacle scroller/dino controller and the score/display logic.

Parameters:
COLS, 8, obstacle columns per row (>=2)
ROWS, 2, display rows the dino can occupy; row 0 = bottom (>=2)
HIT_COL, 7, bit index within a row where the dino stands (0..COLS-1)
LIVES, 3, lives loaded at reset/restart (>=1)
GRACE_TICKS, 4, ticks of invulnerability after a non-fatal hit (0 = none)
CNT_W, 8, hit_count width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
tick  input  1  frame strobe, one clk wide; evaluation happens only on tick
restart  input  1  synchronous restart, one clk wide
obstacle_map  input  ROWS*COLS  row r at bits [r*COLS +: COLS]
dino_row  input  clog2(ROWS)  current dino row
collision  output  1  registered raw overlap, updated each tick
hit  output  1  one-cycle pulse per counted hit
invuln  output  1  high while in GRACE
lives  output  clog2(LIVES+1)  remaining lives
game_over  output  1  sticky until restart/reset
hit_count  output  CNT_W  counted hits, saturating

Behaviour:
- raw_hit = obstacle_map[dino_row*COLS + HIT_COL]; dino_row >= ROWS gives raw_hit = 0.
- Reset (reset=0, async): state RUN, collision 0, hit 0, invuln 0, lives = LIVES, game_over 0, hit_count 0, grace_cnt 0.
- collision: on every tick in RUN or GRACE, collision <= raw_hit; holds between ticks; forced 0 in OVER.
- hit defaults to 0 each cycle; all outputs registered; hit/lives/state changes visible the cycle after the tick.
- States:
  - RUN: tick & raw_hit -> hit=1, hit_count+1 (saturate at all-ones), lives-1. New lives==0 -> OVER, game_over=1. Else GRACE_TICKS>0 -> GRACE, grace_cnt=GRACE_TICKS, invuln=1. Else stay in RUN.
  - GRACE: raw_hit ignored for hit/lives. Each tick decrements grace_cnt. Tick with grace_cnt==1 -> RUN, invuln=0 (exactly GRACE_TICKS ticks immune, including overlaps on the last one).
  - OVER: ticks ignored; all counters frozen.
- restart (any state): next cycle RUN, lives=LIVES, game_over 0, invuln 0, hit_count 0, collision 0, hit 0, grace_cnt 0. restart beats a simultaneous tick; that tick is discarded.
- Overlap held across consecutive ticks in RUN with GRACE_TICKS=0: each tick counts a hit.
- tick high for several cycles: each high cycle is a tick (no edge detection).
- Reset mid-grace or in OVER: immediate return to reset values.

Optional Feature:
HITBOX_WIDE_EN: when defined, raw_hit also includes column HIT_COL-1 of the same row (ignored if HIT_COL==0), i.e. a 2-column hitbox. When undefined, single-column hitbox only. Applies to collision, hit and everything derived from them.

Test Plan:
- Reset then release; defaults; obstacle_map=16'h0080, dino_row=0, tick -> next cycle collision=1, hit pulse 1 cycle, lives 3->2, invuln=1, hit_count=1.
- Same overlap held for 4 more ticks (GRACE_TICKS=4) -> no further hits, lives stay 2; invuln drops after the 4th tick; 5th overlapping tick -> hit, lives=1.
- dino_row=1, obstacle_map=16'h0080 (ground only), tick -> collision=0, no hit; obstacle_map=16'h8000 -> collision=1, hit.
- Three spaced hits -> lives=0, game_over=1, collision forced 0; further overlapping ticks -> no change; restart asserted together with an overlapping tick -> RUN, lives=3, hit_count=0, no hit.
- Overlap without tick for 10 cycles -> collision/hit unchanged; reset pulsed low in GRACE -> all outputs at reset values immediately.
- With HITBOX_WIDE_EN, obstacle_map=16'h0040, dino_row=0, tick -> hit; without the macro -> no hit.
